// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: downstream control, instruction-memory port and IF/ID outputs.
// The perf counter signals exist only when FETCH_PERF_CNT_EN is defined.
interface fetch_stage_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              stall_i;
   logic              flush_i;
   logic              redirect_valid_i;
   logic [ADDR_W-1:0] redirect_pc_i;
   logic              imem_enable_o;
   logic [ADDR_W-1:0] imem_addr_o;
   logic [31:0]       imem_instr_i;
   logic              ifid_valid_o;
   logic [ADDR_W-1:0] ifid_pc_o;
   logic [31:0]       ifid_instr_o;
   logic              fault_o;
   logic [ADDR_W-1:0] fault_pc_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0]       perf_fetch_cnt_o;
   logic [31:0]       perf_stall_cnt_o;
`endif

   // Fetch stage side.
   modport master (
      input  stall_i,
      input  flush_i,
      input  redirect_valid_i,
      input  redirect_pc_i,
      input  imem_instr_i,
      output imem_enable_o,
      output imem_addr_o,
      output ifid_valid_o,
      output ifid_pc_o,
      output ifid_instr_o,
      output fault_o,
      output fault_pc_o
`ifdef FETCH_PERF_CNT_EN
      ,
      output perf_fetch_cnt_o,
      output perf_stall_cnt_o
`endif
   );

   // Pipeline control / instruction memory side.
   modport slave (
      output stall_i,
      output flush_i,
      output redirect_valid_i,
      output redirect_pc_i,
      output imem_instr_i,
      input  imem_enable_o,
      input  imem_addr_o,
      input  ifid_valid_o,
      input  ifid_pc_o,
      input  ifid_instr_o,
      input  fault_o,
      input  fault_pc_o
`ifdef FETCH_PERF_CNT_EN
      ,
      input  perf_fetch_cnt_o,
      input  perf_stall_cnt_o
`endif
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory, fills the IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch/stall performance counters.
module fetch_stage #(
   parameter int unsigned       ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter int unsigned       MEM_WORDS = 32
) (
   input logic           clk_i,
   input logic           rst_i,
   fetch_stage_if.master bus
);

   localparam logic [ADDR_W-1:0] LP_MEM_WORDS = ADDR_W'(MEM_WORDS);
   localparam logic [ADDR_W:0]   LP_PC_STEP   = (ADDR_W+1)'(4);

   typedef enum logic [1:0] {StBoot, StFetch, StHalted} state_e;

   state_e            r_state;
   state_e            w_state_next;

   logic [ADDR_W-1:0] r_pc;
   logic              r_ifid_valid;
   logic [ADDR_W-1:0] r_ifid_pc;
   logic [31:0]       r_ifid_instr;
   logic              r_fault;
   logic [ADDR_W-1:0] r_fault_pc;

   logic [ADDR_W:0]   w_pc_inc_full;
   logic [ADDR_W-1:0] w_pc_inc;
   logic              w_inc_bad;
   logic              w_redir_bad;

   logic              w_imem_enable;
   logic              w_pc_load;
   logic [ADDR_W-1:0] w_pc_next;
   logic              w_ifid_clear;
   logic              w_ifid_load;
   logic              w_fault_set;
   logic [ADDR_W-1:0] w_fault_pc;

   // Carry out of the increment counts as out of range: wrapping to 0 is not a legal fetch.
   assign w_pc_inc_full = {1'b0, r_pc} + LP_PC_STEP;
   assign w_pc_inc      = w_pc_inc_full[ADDR_W-1:0];
   assign w_inc_bad     = w_pc_inc_full[ADDR_W] || ((w_pc_inc >> 2) >= LP_MEM_WORDS);
   assign w_redir_bad   = (bus.redirect_pc_i[1:0] != 2'b00) ||
                          ((bus.redirect_pc_i >> 2) >= LP_MEM_WORDS);

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= StBoot;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StBoot: begin
            w_state_next = StFetch;
         end
         StFetch: begin
            if (bus.redirect_valid_i) begin
               if (w_redir_bad) begin
                  w_state_next = StHalted;
               end
            end else if (!bus.flush_i && !bus.stall_i && w_inc_bad) begin
               w_state_next = StHalted;
            end
         end
         StHalted: begin
            w_state_next = StHalted;
         end
         default: begin
            w_state_next = StBoot;
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs / datapath strobes
   always_comb begin
      w_imem_enable = 1'b0;
      w_pc_load     = 1'b0;
      w_pc_next     = r_pc;
      w_ifid_clear  = 1'b0;
      w_ifid_load   = 1'b0;
      w_fault_set   = 1'b0;
      w_fault_pc    = '0;
      unique case (r_state)
         StBoot: begin
            w_ifid_clear = 1'b1;
         end
         StFetch: begin
            w_imem_enable = 1'b1;
            if (bus.redirect_valid_i) begin
               // The wrong-path word fetched this cycle is dropped either way.
               w_ifid_clear = 1'b1;
               if (w_redir_bad) begin
                  w_fault_set = 1'b1;
                  w_fault_pc  = bus.redirect_pc_i;
               end else begin
                  w_pc_load = 1'b1;
                  w_pc_next = bus.redirect_pc_i;
               end
            end else if (bus.flush_i) begin
               w_ifid_clear = 1'b1;
            end else if (!bus.stall_i) begin
               w_ifid_load = 1'b1;
               w_pc_load   = 1'b1;
               w_pc_next   = w_pc_inc;
               if (w_inc_bad) begin
                  w_fault_set = 1'b1;
                  w_fault_pc  = w_pc_inc;
               end
            end
         end
         StHalted: begin
            w_ifid_clear = 1'b1;
         end
         default: begin
            w_ifid_clear = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------- datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_pc         <= RESET_PC;
         r_ifid_valid <= 1'b0;
         r_ifid_pc    <= '0;
         r_ifid_instr <= '0;
         r_fault      <= 1'b0;
         r_fault_pc   <= '0;
      end else begin
         if (w_pc_load) begin
            r_pc <= w_pc_next;
         end
         if (w_ifid_clear) begin
            r_ifid_valid <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
         end else if (w_ifid_load) begin
            r_ifid_valid <= 1'b1;
            r_ifid_pc    <= r_pc;
            r_ifid_instr <= bus.imem_instr_i;
         end
         if (w_fault_set) begin
            r_fault    <= 1'b1;
            r_fault_pc <= w_fault_pc;
         end
      end
   end

   assign bus.imem_enable_o = w_imem_enable;
   assign bus.imem_addr_o   = r_pc;
   assign bus.ifid_valid_o  = r_ifid_valid;
   assign bus.ifid_pc_o     = r_ifid_pc;
   assign bus.ifid_instr_o  = r_ifid_instr;
   assign bus.fault_o       = r_fault;
   assign bus.fault_pc_o    = r_fault_pc;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_perf_fetch;
   logic [31:0] r_perf_stall;
   logic        w_stall_evt;

   assign w_stall_evt = (r_state == StFetch) && bus.stall_i &&
                        !bus.flush_i && !bus.redirect_valid_i;

   // Only an advance loads IF/ID, so the load strobe doubles as the fetch event.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_perf_fetch <= '0;
         r_perf_stall <= '0;
      end else begin
         if (w_ifid_load) begin
            r_perf_fetch <= r_perf_fetch + 32'd1;
         end
         if (w_stall_evt) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign bus.perf_fetch_cnt_o = r_perf_fetch;
   assign bus.perf_stall_cnt_o = r_perf_stall;
`endif

`ifndef SYNTHESIS
   a_fault_halted : assert property (@(posedge clk_i) disable iff (rst_i)
      r_fault |-> (r_state == StHalted));
   a_bubble_zero : assert property (@(posedge clk_i) disable iff (rst_i)
      !r_ifid_valid |-> (r_ifid_instr == '0) && (r_ifid_pc == '0));
   a_halt_frozen : assert property (@(posedge clk_i) disable iff (rst_i)
      (r_state == StHalted) |=> (r_state == StHalted) && $stable(r_pc) && $stable(r_fault_pc));
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the instruction memory.
- Owns the program counter and drives the memory's enable and byte address.
- Captures the combinational instruction word returned in the same cycle into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect from downstream, and halts with a sticky fault on a misaligned or out-of-range PC.

Parameters:
- ADDR_W, 16, byte-address width of PC and memory address.
- RESET_PC, 16'h0000, PC loaded on reset.
- MEM_WORDS, 32, number of 32-bit words in instruction memory; legal PCs are 0 .. 4*MEM_WORDS-4.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  synchronous active-high reset.
- stall_i  in  1  downstream stall; hold PC and IF/ID.
- flush_i  in  1  kill IF/ID contents (bubble).
- redirect_valid_i  in  1  load new PC (taken branch/jump).
- redirect_pc_i  in  ADDR_W  redirect target byte address.
- imem_enable_o  out  1  instruction memory enable.
- imem_addr_o  out  ADDR_W  instruction memory byte address.
- imem_instr_i  in  32  instruction word from memory, combinational from imem_addr_o.
- ifid_valid_o  out  1  IF/ID holds a real instruction.
- ifid_pc_o  out  ADDR_W  PC of the IF/ID instruction.
- ifid_instr_o  out  32  IF/ID instruction; 32'h0 (NO_OP) when not valid.
- fault_o  out  1  sticky fetch fault.
- fault_pc_o  out  ADDR_W  offending PC, captured when the fault is raised.

Behaviour:
- Reset (rst_i=1 at clock edge, any state, mid-stall or mid-redirect):
  - pc_q=RESET_PC, state=BOOT.
  - ifid_valid_o=0, ifid_pc_o=0, ifid_instr_o=32'h0.
  - fault_o=0, fault_pc_o=0.
- Outputs are combinational from state: imem_enable_o=1 only in FETCH; imem_addr_o=pc_q always.
- States:
  - BOOT: enable low, IF/ID stays invalid; next cycle -> FETCH unconditionally. All inputs are ignored.
  - FETCH: normal operation; priority redirect > flush > stall > advance.
  - HALTED: enable low, pc_q frozen, IF/ID invalid with instr 32'h0; all inputs ignored; exit only via reset.
- FETCH, redirect_valid_i=1 (overrides stall_i and flush_i):
  - If redirect_pc_i[1:0]!=0 or (redirect_pc_i>>2)>=MEM_WORDS -> HALTED, fault_o<=1, fault_pc_o<=redirect_pc_i.
  - Else pc_q<=redirect_pc_i.
  - In both cases IF/ID is invalidated (valid=0, instr=0, pc=0). The wrong-path instruction fetched this cycle is discarded.
- FETCH, flush_i=1 with no redirect: IF/ID invalidated; pc_q held, so the same PC is refetched next cycle.
- FETCH, stall_i=1 with no redirect/flush: pc_q and IF/ID hold their values; imem_enable_o stays 1.
- FETCH, advance (no redirect/flush/stall):
  - ifid_valid_o<=1, ifid_pc_o<=pc_q, ifid_instr_o<=imem_instr_i.
  - pc_q<=pc_q+4, modulo 2^ADDR_W.
  - If the incremented PC is out of range ((pc_q+4)>>2>=MEM_WORDS, including wrap past 16'hFFFC) -> HALTED next cycle, fault_o<=1, fault_pc_o<=pc_q+4. The instruction latched on this same edge remains valid in IF/ID until the next edge, then is cleared.
- Latency: a PC is presented in cycle N; its instruction is visible on ifid_* in cycle N+1. Throughput is one instruction per unstalled cycle.
- Once set, fault_o and fault_pc_o hold until reset.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds output ports perf_fetch_cnt_o[31:0] and perf_stall_cnt_o[31:0].
  - perf_fetch_cnt_o increments on each advance.
  - perf_stall_cnt_o increments on each FETCH cycle with stall_i=1 and no redirect/flush.
  - Both cleared by reset, wrap at 2^32, frozen in HALTED.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset sequence with RESET_PC=0 -> cycle 1 after reset: enable=0, ifid_valid=0; cycle 2: addr=0x0000, enable=1; cycle 3: ifid_pc=0x0000, ifid_instr=mem[0], addr=0x0004.
- Stall held 3 cycles while pc_q=0x0008 -> addr stays 0x0008; ifid_pc and ifid_instr unchanged for 3 cycles; after release, ifid_pc=0x0008 next cycle.
- redirect_valid_i=1, redirect_pc_i=0x0040, asserted together with stall_i=1 -> next cycle: addr=0x0040, ifid_valid=0; following cycle: ifid_pc=0x0040.
- flush_i=1 alone at pc_q=0x0010 -> ifid_valid=0 and ifid_instr=0; addr stays 0x0010, then ifid_pc=0x0010.
- Misaligned redirect 0x0006 -> HALTED, fault_o=1, fault_pc_o=0x0006, enable=0; further redirect to 0x0000 is ignored; rst_i=1 clears fault_o and re-enters BOOT.
- Sequential fetch up to 0x007C with MEM_WORDS=32 -> ifid_pc=0x007C valid for one cycle; then fault_o=1, fault_pc_o=0x0080, enable=0. With FETCH_PERF_CNT_EN defined, perf_fetch_cnt_o=32.
